// File: rtl/my_types.sv
// my_types: video-mode, mode-code and sequencer-state definitions shared by the sequencer and its bench
package my_types;
    typedef enum logic [2:0] {
        VIDEO_MODE_1080P,
        VIDEO_MODE_1080I,
        VIDEO_MODE_720P,
        VIDEO_MODE_480P,
        VIDEO_MODE_480I
    } VideoMode;
    typedef enum logic [2:0] {IDLE, BLANK, PLL_RST, WAIT_LOCK, SETTLE, APPLY} seq_state_t;
    localparam logic [7:0] MODE_1080p = 8'h01;
    localparam logic [7:0] MODE_1080i = 8'h02;
    localparam logic [7:0] MODE_720p  = 8'h03;
    localparam logic [7:0] MODE_480p  = 8'h04;
    localparam logic [7:0] MODE_480i  = 8'h05;
endpackage

// File: rtl/mode_code_decoder.sv
// mode_code_decoder: maps an 8-bit requested mode code onto a VideoMode plus a valid flag
module mode_code_decoder
    import my_types::*;
(
    input  logic [7:0] code_i,
    output VideoMode   mode_o,
    output logic       valid_o
);
    assign valid_o = code_i inside {MODE_1080p, MODE_1080i, MODE_720p, MODE_480p, MODE_480i};
    assign mode_o  = code_i == MODE_1080i ? VIDEO_MODE_1080I :
                     code_i == MODE_720p  ? VIDEO_MODE_720P  :
                     code_i == MODE_480p  ? VIDEO_MODE_480P  :
                     code_i == MODE_480i  ? VIDEO_MODE_480I  : VIDEO_MODE_1080P;
endmodule

// File: rtl/mode_switch_sequencer.sv
// mode_switch_sequencer: blanks video, reconfigures the pixel PLL and applies a newly requested mode.
// Define MODE_SWITCH_RETRY_EN to retry a lost PLL lock up to three times before flagging lock_error.
module mode_switch_sequencer
    import my_types::*;
#(
    parameter int BLANK_CYCLES   = 16,
    parameter int PLL_RST_CYCLES = 64,
    parameter int LOCK_TIMEOUT   = 1048576,
    parameter int SETTLE_CYCLES  = 1024
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] mode_req,
    input  logic       pll_locked,
    output logic       pll_reset,
    output VideoMode   pll_mode,
    output VideoMode   videoMode,
    output logic       blank,
    output logic       mode_applied,
    output logic       busy,
    output logic       lock_error
);
    localparam int M1 = BLANK_CYCLES > PLL_RST_CYCLES ? BLANK_CYCLES : PLL_RST_CYCLES;
    localparam int M2 = LOCK_TIMEOUT > SETTLE_CYCLES ? LOCK_TIMEOUT : SETTLE_CYCLES;
    localparam int CW = $clog2((M1 > M2 ? M1 : M2) + 1);
    localparam logic [CW-1:0] BLANK_LAST  = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] RST_LAST    = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
`ifdef MODE_SWITCH_RETRY_EN
    localparam logic [1:0] LAST_TRY = 2'd3;
`else
    localparam logic [1:0] LAST_TRY = 2'd0;
`endif

    seq_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    try_q, try_d;
    logic [7:0]    req_q;
    VideoMode      tgt_q, tgt_d, pll_mode_q, pll_mode_d, mode_q, dec_mode;
    logic          applied_q, err_q, err_d, dec_valid, req_new, restart;

    mode_code_decoder u_dec (.code_i(mode_req), .mode_o(dec_mode), .valid_o(dec_valid));

    // A request only counts on the cycle the code changes; re-requesting the live mode is a no-op
    assign req_new    = dec_valid && mode_req != req_q && !(state_q == IDLE && dec_mode == mode_q);
    assign restart    = req_new && state_q inside {PLL_RST, WAIT_LOCK, SETTLE};
    assign tgt_d      = req_new ? dec_mode : tgt_q;
    assign pll_mode_d = state_d == PLL_RST && (state_q != PLL_RST || restart) ? tgt_d : pll_mode_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        try_d   = try_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req_new) state_d = BLANK;
            end
            BLANK: if (cnt_q == BLANK_LAST) begin
                state_d = PLL_RST;
                cnt_d   = '0;
                try_d   = '0;
            end
            PLL_RST: if (cnt_q == RST_LAST) begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
            WAIT_LOCK: if (pll_locked) begin
                state_d = SETTLE;
                cnt_d   = '0;
            end else if (cnt_q == LOCK_LAST) begin
                cnt_d   = '0;
                state_d = try_q == LAST_TRY ? IDLE : PLL_RST;
                err_d   = try_q == LAST_TRY;
                try_d   = try_q + 1'b1;
            end
            SETTLE: if (!pll_locked) begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end else if (cnt_q == SETTLE_LAST) begin
                state_d = APPLY;
                cnt_d   = '0;
            end
            APPLY: begin
                state_d = IDLE;
                cnt_d   = '0;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        if (restart) begin
            state_d = PLL_RST;
            cnt_d   = '0;
            try_d   = '0;
        end
    end

    always_ff @(posedge clock) begin
        req_q <= mode_req;
        if (reset) begin
            state_q    <= BLANK;
            cnt_q      <= '0;
            try_q      <= '0;
            tgt_q      <= VIDEO_MODE_1080P;
            pll_mode_q <= VIDEO_MODE_1080P;
            mode_q     <= VIDEO_MODE_1080P;
            applied_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            try_q      <= try_d;
            tgt_q      <= tgt_d;
            pll_mode_q <= pll_mode_d;
            mode_q     <= state_q == APPLY ? pll_mode_q : mode_q;
            applied_q  <= state_q == APPLY;
            err_q      <= err_d;
        end
    end

    assign pll_reset    = state_q == PLL_RST;
    assign pll_mode     = pll_mode_q;
    assign videoMode    = mode_q;
    assign busy         = state_q != IDLE;
    assign blank        = busy || err_q;
    assign mode_applied = applied_q;
    assign lock_error   = err_q;
endmodule

// File: tb/tb_mode_switch_sequencer.sv
// tb_mode_switch_sequencer: vector table, multi-cycle corner sequences and randomized transactions vs a reference model
module tb_mode_switch_sequencer;
    import my_types::*;
    localparam int B = 16, P = 64, LT = 1000, S = 100;
`ifdef MODE_SWITCH_RETRY_EN
    localparam int ATT = 4;
`else
    localparam int ATT = 1;
`endif
    localparam int OK_BUSY  = B + P + S + 2;
    localparam int ERR_BUSY = B + ATT * (P + LT);
    localparam int LIMIT    = ERR_BUSY + 200;

    typedef struct packed {
        logic [7:0] code;
        logic       lk;
        VideoMode   tgt;
        VideoMode   mode;
        int         busy;
        int         rst;
        int         app;
        logic       err;
    } vec_t;

    logic       clock = 1'b0, reset = 1'b1, pll_locked = 1'b1;
    logic [7:0] mode_req = MODE_1080p;
    logic       pll_reset, blank, mode_applied, busy, lock_error;
    VideoMode   pll_mode, videoMode, pll_at;
    int         tests = 0, fails = 0, bc, rc, ac, first_rst;
    vec_t       tbl[8];
    logic [7:0] codes[5] = '{MODE_1080p, MODE_1080i, MODE_720p, MODE_480p, MODE_480i};
    VideoMode   modes[5] = '{VIDEO_MODE_1080P, VIDEO_MODE_1080I, VIDEO_MODE_720P, VIDEO_MODE_480P, VIDEO_MODE_480I};

    always #5 clock = ~clock;

    mode_switch_sequencer #(
        .BLANK_CYCLES(B), .PLL_RST_CYCLES(P), .LOCK_TIMEOUT(LT), .SETTLE_CYCLES(S)
    ) dut (
        .clock(clock), .reset(reset), .mode_req(mode_req), .pll_locked(pll_locked),
        .pll_reset(pll_reset), .pll_mode(pll_mode), .videoMode(videoMode), .blank(blank),
        .mode_applied(mode_applied), .busy(busy), .lock_error(lock_error)
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic measure(input int limit, input bit stop);
        bc = 0; rc = 0; ac = 0; first_rst = 0; pll_at = VIDEO_MODE_1080P;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if (busy) bc++;
            if (pll_reset && rc == 0) begin
                first_rst = i;
                pll_at = pll_mode;
            end
            if (pll_reset) rc++;
            if (mode_applied) ac++;
            if (stop && bc > 0 && !busy) break;
        end
    endtask

    task automatic boot;
        reset = 1'b1; mode_req = MODE_1080p; pll_locked = 1'b1;
        tick();
        check("rst_video", videoMode, VIDEO_MODE_1080P);
        check("rst_pll_mode", pll_mode, VIDEO_MODE_1080P);
        check("rst_lock_error", lock_error, 0);
        check("rst_applied", mode_applied, 0);
        check("rst_blank", blank, 1);
        check("rst_busy", busy, 1);
        check("rst_pll_reset", pll_reset, 0);
        reset = 1'b0;
        measure(LIMIT, 1);
        check("boot_busy", bc + 1, OK_BUSY);
        check("boot_first_rst", first_rst, B);
        check("boot_rst_len", rc, P);
        check("boot_applied", ac, 1);
        check("boot_video", videoMode, VIDEO_MODE_1080P);
        check("boot_blank", blank, 0);
    endtask

    function automatic void ref_decode(input logic [7:0] c, output bit v, output VideoMode m);
        v = 1'b0;
        m = VIDEO_MODE_1080P;
        for (int k = 0; k < 5; k++)
            if (c == codes[k]) begin
                v = 1'b1;
                m = modes[k];
            end
    endfunction

    initial begin
        VideoMode cur, dm;
        logic [7:0] prev, code;
        bit err, lk, dv, det;
        int sel;
        tbl[0] = '{MODE_720p,  1'b1, VIDEO_MODE_720P,  VIDEO_MODE_720P,  OK_BUSY,  P,       1, 1'b0};
        tbl[1] = '{8'hFF,      1'b1, VIDEO_MODE_720P,  VIDEO_MODE_720P,  0,        0,       0, 1'b0};
        tbl[2] = '{MODE_720p,  1'b1, VIDEO_MODE_720P,  VIDEO_MODE_720P,  0,        0,       0, 1'b0};
        tbl[3] = '{MODE_480p,  1'b0, VIDEO_MODE_480P,  VIDEO_MODE_720P,  ERR_BUSY, ATT * P, 0, 1'b1};
        tbl[4] = '{8'h00,      1'b1, VIDEO_MODE_720P,  VIDEO_MODE_720P,  0,        0,       0, 1'b1};
        tbl[5] = '{MODE_1080i, 1'b1, VIDEO_MODE_1080I, VIDEO_MODE_1080I, OK_BUSY,  P,       1, 1'b0};
        tbl[6] = '{MODE_480i,  1'b1, VIDEO_MODE_480I,  VIDEO_MODE_480I,  OK_BUSY,  P,       1, 1'b0};
        tbl[7] = '{MODE_1080p, 1'b1, VIDEO_MODE_1080P, VIDEO_MODE_1080P, OK_BUSY,  P,       1, 1'b0};
        boot();

        for (int i = 0; i < 8; i++) begin
            mode_req = tbl[i].code;
            pll_locked = tbl[i].lk;
            measure(tbl[i].busy == 0 ? 5 : LIMIT, 1);
            check($sformatf("row%0d_busy", i), bc, tbl[i].busy);
            check($sformatf("row%0d_pll_reset", i), rc, tbl[i].rst);
            check($sformatf("row%0d_applied", i), ac, tbl[i].app);
            check($sformatf("row%0d_video", i), videoMode, tbl[i].mode);
            check($sformatf("row%0d_lock_error", i), lock_error, int'(tbl[i].err));
            check($sformatf("row%0d_blank", i), blank, int'(tbl[i].err));
            if (tbl[i].rst != 0) begin
                check($sformatf("row%0d_first_rst", i), first_rst, B + 1);
                check($sformatf("row%0d_pll_mode", i), pll_at, tbl[i].tgt);
            end
        end

        // request changed while still blanking: only the target moves
        mode_req = MODE_480p; pll_locked = 1'b1;
        measure(5, 0);
        check("blk_upd_busy0", bc, 5);
        mode_req = MODE_720p;
        measure(LIMIT, 1);
        check("blk_upd_busy", bc, OK_BUSY - 5);
        check("blk_upd_first_rst", first_rst, B - 4);
        check("blk_upd_pll_mode", pll_at, VIDEO_MODE_720P);
        check("blk_upd_applied", ac, 1);
        check("blk_upd_video", videoMode, VIDEO_MODE_720P);

        // new request while waiting for lock restarts at PLL reset
        mode_req = MODE_480p; pll_locked = 1'b0;
        measure(B + P + 100, 0);
        check("rstrt_busy0", bc, B + P + 100);
        check("rstrt_rst0", rc, P);
        check("rstrt_applied0", ac, 0);
        mode_req = MODE_480i; pll_locked = 1'b1;
        measure(LIMIT, 1);
        check("rstrt_first_rst", first_rst, 1);
        check("rstrt_pll_mode", pll_at, VIDEO_MODE_480I);
        check("rstrt_rst", rc, P);
        check("rstrt_busy", bc, P + S + 2);
        check("rstrt_applied", ac, 1);
        check("rstrt_video", videoMode, VIDEO_MODE_480I);

        // lock lost mid-settle: settle is counted again from zero
        mode_req = MODE_1080i; pll_locked = 1'b1;
        measure(B + P + 21, 0);
        check("drop_applied0", ac, 0);
        pll_locked = 1'b0;
        measure(5, 0);
        check("drop_busy", bc, 5);
        check("drop_applied1", ac, 0);
        pll_locked = 1'b1;
        measure(LIMIT, 1);
        check("drop_settle_busy", bc, S + 1);
        check("drop_applied", ac, 1);
        check("drop_video", videoMode, VIDEO_MODE_1080I);

        // reset in the middle of a lock wait
        mode_req = MODE_720p; pll_locked = 1'b0;
        measure(B + P + 50, 0);
        check("midrst_applied", ac, 0);
        boot();

        cur = VIDEO_MODE_1080P; err = 1'b0; prev = MODE_1080p;
        for (int n = 0; n < 30; n++) begin
            sel = int'($urandom_range(0, 7));
            code = sel < 5 ? codes[sel] : sel == 5 ? 8'hFF : sel == 6 ? 8'h00 : 8'($urandom);
            lk = $urandom_range(0, 9) != 0;
            ref_decode(code, dv, dm);
            det = dv && code != prev && dm != cur;
            mode_req = code;
            pll_locked = lk;
            measure(det ? LIMIT : 5, 1);
            check($sformatf("rnd%0d_busy", n), bc, det ? (lk ? OK_BUSY : ERR_BUSY) : 0);
            check($sformatf("rnd%0d_pll_reset", n), rc, det ? (lk ? P : ATT * P) : 0);
            check($sformatf("rnd%0d_applied", n), ac, int'(det && lk));
            if (det) begin
                cur = lk ? dm : cur;
                err = !lk;
            end
            prev = code;
            check($sformatf("rnd%0d_video", n), videoMode, cur);
            check($sformatf("rnd%0d_lock_error", n), lock_error, int'(err));
            check($sformatf("rnd%0d_blank", n), blank, int'(err));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
